// File: rtl/button_debounce_multi.sv
// Multi-channel button debouncer: two-flop synchroniser, prescaled sampling,
// run-length acceptance, one-cycle press/release pulses and optional auto-repeat.
module button_debounce_multi #(
  parameter int   CHANNELS     = 4,
  parameter int   SAMPLE_DIV   = 1000,
  parameter int   STABLE_COUNT = 8,
  parameter logic RESET_LEVEL  = 1'b0,
  parameter int   REPEAT_DELAY = 0,
  parameter int   REPEAT_RATE  = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] inbutton,
  output logic [CHANNELS-1:0] outbutton,
  output logic [CHANNELS-1:0] press,
  output logic [CHANNELS-1:0] release_pulse,
  output logic [CHANNELS-1:0] repeat_pulse
);

  localparam int PW   = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int CW   = (STABLE_COUNT > 1) ? $clog2(STABLE_COUNT) : 1;
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

  localparam logic [PW-1:0] PDIV_LAST = PW'(SAMPLE_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_COUNT - 1);
  localparam logic [RW-1:0] DLY_LAST  = RW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [RW-1:0] RATE_LAST = RW'((REPEAT_RATE > 0) ? REPEAT_RATE - 1 : 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    RATE  = 2'd2
  } rstate_t;

  logic [CHANNELS-1:0] sync1;
  logic [CHANNELS-1:0] sync2;
  logic [PW-1:0]       pcnt;
  logic                tick;

  // Two-stage synchroniser for the raw asynchronous button levels
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= {CHANNELS{RESET_LEVEL}};
      sync2 <= {CHANNELS{RESET_LEVEL}};
    end else begin
      sync1 <= inbutton;
      sync2 <= sync1;
    end
  end

  // Shared sample prescaler; with SAMPLE_DIV=1 the count stays 0 so tick is constant
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt <= '0;
    end else if (pcnt == PDIV_LAST) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PW'(1);
    end
  end

  assign tick = (pcnt == PDIV_LAST);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [CW-1:0] cnt;
    logic [RW-1:0] rcnt;
    rstate_t       st;
    logic          level;
    logic          press_q;
    logic          release_q;
    logic          repeat_q;
    logic          accept;

    // A change is taken on the tick that completes the run of differing samples
    assign accept = tick && (sync2[i] != level) && (cnt == CNT_LAST);

    // Per-channel stability counter, event pulses and auto-repeat state machine
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        level     <= RESET_LEVEL;
        cnt       <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        repeat_q  <= 1'b0;
        st        <= IDLE;
        rcnt      <= '0;
      end else begin
        press_q   <= accept && sync2[i];
        release_q <= accept && !sync2[i];
        repeat_q  <= 1'b0;

        if (tick) begin
          if (sync2[i] == level) begin
            cnt <= '0;
          end else if (cnt == CNT_LAST) begin
            level <= sync2[i];
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end else begin
          cnt <= cnt;
        end

        if (REPEAT_DELAY == 0) begin
          st   <= IDLE;
          rcnt <= '0;
        end else if (accept) begin
          // Press arms the delay; release returns to idle without a repeat pulse
          st   <= sync2[i] ? DELAY : IDLE;
          rcnt <= '0;
        end else if (tick) begin
          case (st)
            IDLE: begin
              rcnt <= '0;
            end
            DELAY: begin
              if (rcnt == DLY_LAST) begin
                repeat_q <= 1'b1;
                rcnt     <= '0;
                st       <= RATE;
              end else begin
                rcnt <= rcnt + RW'(1);
              end
            end
            RATE: begin
              if (rcnt == RATE_LAST) begin
                repeat_q <= 1'b1;
                rcnt     <= '0;
              end else begin
                rcnt <= rcnt + RW'(1);
              end
            end
            default: begin
              st   <= IDLE;
              rcnt <= '0;
            end
          endcase
        end else begin
          st   <= st;
          rcnt <= rcnt;
        end
      end
    end

    assign outbutton[i]     = level;
    assign press[i]         = press_q;
    assign release_pulse[i] = release_q;
    assign repeat_pulse[i]  = repeat_q;
  end

endmodule

// File: tb/tb_button_debounce_multi.sv
// Directed bench for button_debounce_multi: an unprescaled auto-repeat instance
// and a prescaled instance, checked through an edge-stamped expectation queue.
module tb_button_debounce_multi;

  logic       clk = 1'b0;
  logic       reset_a, reset_b;
  logic [1:0] in_a, in_b;
  logic [1:0] out_a, press_a, rel_a, rep_a;
  logic [1:0] out_b, press_b, rel_b, rep_b;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    int         at;
    int         sel;
    logic [1:0] val;
    string      tag;
  } sb_entry_t;

  sb_entry_t sb[$];

  button_debounce_multi #(
    .CHANNELS(2), .SAMPLE_DIV(1), .STABLE_COUNT(4), .RESET_LEVEL(1'b0),
    .REPEAT_DELAY(3), .REPEAT_RATE(2)
  ) dut_a (
    .clk(clk), .reset(reset_a), .inbutton(in_a), .outbutton(out_a),
    .press(press_a), .release_pulse(rel_a), .repeat_pulse(rep_a)
  );

  button_debounce_multi #(
    .CHANNELS(2), .SAMPLE_DIV(3), .STABLE_COUNT(4), .RESET_LEVEL(1'b0),
    .REPEAT_DELAY(0), .REPEAT_RATE(1)
  ) dut_b (
    .clk(clk), .reset(reset_b), .inbutton(in_b), .outbutton(out_b),
    .press(press_b), .release_pulse(rel_b), .repeat_pulse(rep_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [1:0] pick(input int sel);
    case (sel)
      0: pick = out_a;
      1: pick = press_a;
      2: pick = rel_a;
      3: pick = rep_a;
      4: pick = out_b;
      5: pick = press_b;
      6: pick = rel_b;
      7: pick = rep_b;
      default: pick = 2'bxx;
    endcase
  endfunction

  task automatic exp(input int at, input int sel, input logic [1:0] val, input string tag);
    sb_entry_t e;
    e.at = at; e.sel = sel; e.val = val; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic exp_rng(input int from, input int to, input int sel, input logic [1:0] val,
                         input string tag);
    for (int k = from; k <= to; k++) exp(k, sel, val, tag);
  endtask

  task automatic check_due();
    logic [1:0] obs;
    for (int k = sb.size() - 1; k >= 0; k--) begin
      if (sb[k].at == cyc) begin
        obs = pick(sb[k].sel);
        n_tests++;
        assert (obs === sb[k].val) else begin
          n_fail++;
          $error("FAIL %s edge %0d: observed %b expected %b", sb[k].tag, cyc, obs, sb[k].val);
        end
        sb.delete(k);
      end
    end
  endtask

  task automatic step_to(input int target);
    while (cyc < target) begin
      @(negedge clk);
      check_due();
    end
  endtask

  bit pat [0:7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  initial begin
    reset_a = 1'b0; reset_b = 1'b0;
    in_a = 2'b11; in_b = 2'b00;

    // reset held with both inputs high
    step_to(1);
    exp_rng(2, 4, 0, 2'b00, "rst_out");
    exp_rng(2, 4, 1, 2'b00, "rst_press");
    exp_rng(2, 4, 2, 2'b00, "rst_release");
    exp_rng(2, 4, 3, 2'b00, "rst_repeat");
    step_to(4);
    reset_a = 1'b1;
    exp_rng(5, 9, 0, 2'b00, "rst_out_wait");
    exp(10, 0, 2'b11, "rst_out_set");
    exp(9, 1, 2'b00, "rst_press_early");
    exp(10, 1, 2'b11, "rst_press");
    exp(11, 1, 2'b00, "rst_press_single");
    exp(13, 3, 2'b11, "rst_repeat_first");
    exp(14, 3, 2'b00, "rst_repeat_gap");
    step_to(12);
    in_a = 2'b00;
    exp(17, 3, 2'b11, "rst_repeat_rate");
    exp(18, 2, 2'b11, "rst_release_both");
    exp(18, 3, 2'b00, "rst_no_repeat_at_release");
    exp(18, 0, 2'b00, "rst_out_clear");

    // clean press and release on ch0
    step_to(20);
    in_a = 2'b01;
    exp_rng(21, 25, 0, 2'b00, "clean_out_wait");
    exp(26, 0, 2'b01, "clean_out");
    exp(25, 1, 2'b00, "clean_press_early");
    exp(26, 1, 2'b01, "clean_press");
    exp(27, 1, 2'b00, "clean_press_single");
    step_to(28);
    in_a = 2'b00;
    exp(33, 2, 2'b00, "clean_release_early");
    exp(34, 2, 2'b01, "clean_release");
    exp(35, 2, 2'b00, "clean_release_single");
    exp(33, 3, 2'b01, "clean_repeat");
    exp(34, 3, 2'b00, "clean_no_repeat_at_release");
    exp(34, 0, 2'b00, "clean_out_low");

    // bounce on ch0: the first run of three 1s must not be accepted
    step_to(36);
    exp_rng(37, 45, 0, 2'b00, "bounce_hold");
    exp(46, 0, 2'b01, "bounce_out");
    exp_rng(37, 45, 1, 2'b00, "bounce_no_press");
    exp(46, 1, 2'b01, "bounce_press");
    exp_rng(47, 50, 1, 2'b00, "bounce_press_once");
    for (int i = 0; i < 8; i++) begin
      in_a = {1'b0, pat[i]};
      step_to(37 + i);
    end
    step_to(52);
    in_a = 2'b00;
    exp(58, 2, 2'b01, "bounce_release");

    // auto-repeat on ch1
    step_to(60);
    in_a = 2'b10;
    exp(66, 1, 2'b10, "rep_press");
    exp_rng(66, 68, 3, 2'b00, "rep_delay_quiet");
    exp(69, 3, 2'b10, "rep_first");
    exp(70, 3, 2'b00, "rep_gap1");
    exp(71, 3, 2'b10, "rep_second");
    exp(72, 3, 2'b00, "rep_gap2");
    exp(73, 3, 2'b10, "rep_third");
    step_to(74);
    in_a = 2'b00;
    exp(79, 3, 2'b10, "rep_last");
    exp(80, 2, 2'b10, "rep_release");
    exp(80, 3, 2'b00, "rep_none_at_release");
    exp_rng(81, 82, 3, 2'b00, "rep_stopped");

    // simultaneous: ch0 rises while ch1 falls
    step_to(82);
    in_a = 2'b10;
    exp(88, 1, 2'b10, "sim_setup_press");
    step_to(90);
    in_a = 2'b01;
    exp(96, 1, 2'b01, "sim_press");
    exp(96, 2, 2'b10, "sim_release");
    exp(96, 0, 2'b01, "sim_out");
    exp(96, 3, 2'b00, "sim_no_repeat");
    step_to(100);
    in_a = 2'b00;

    // prescaled instance: ticks fall on edges 111, 114, 117, ...
    step_to(108);
    reset_b = 1'b1;
    step_to(110);
    in_b = 2'b01;
    exp_rng(111, 122, 4, 2'b00, "pre_out_wait");
    exp(123, 4, 2'b01, "pre_out");
    exp(122, 5, 2'b00, "pre_press_early");
    exp(123, 5, 2'b01, "pre_press");
    exp(124, 5, 2'b00, "pre_press_single");
    step_to(124);
    in_b = 2'b00;
    exp(137, 4, 2'b01, "pre_out_still_high");
    exp(138, 4, 2'b00, "pre_rel_out");
    exp(137, 6, 2'b00, "pre_release_early");
    exp(138, 6, 2'b01, "pre_release");

    // reset after three matching samples discards the run
    step_to(140);
    in_b = 2'b01;
    step_to(151);
    reset_b = 1'b0;
    exp(152, 4, 2'b00, "mid_rst_out");
    exp(152, 5, 2'b00, "mid_rst_press");
    step_to(153);
    reset_b = 1'b1;
    exp_rng(154, 164, 4, 2'b00, "mid_rst_hold");
    exp_rng(154, 164, 5, 2'b00, "mid_rst_no_press");
    exp(165, 4, 2'b01, "mid_rst_out_set");
    exp(165, 5, 2'b01, "mid_rst_press");
    exp(165, 7, 2'b00, "pre_no_repeat");

    step_to(170);
    n_tests++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL sb_drain: observed %0d pending expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/button_debounce_multi.md
# button_debounce_multi

Parametrised multi-channel debouncer for the pong controls; the successor to the single-button 8-sample debouncer. Each channel is synchronised, then sampled on a shared prescaled tick. It accepts a level change only after a configurable run of identical samples. It emits one-cycle press/release pulses and an optional auto-repeat pulse while a button is held, so paddle logic can consume events instead of raw levels.

## Interface
- CHANNELS, 4: number of independent button channels (≥1).
- SAMPLE_DIV, 1000: clk cycles per sample tick (≥1; 1 = sample every cycle).
- STABLE_COUNT, 8: consecutive differing samples required to accept a change (≥1).
- RESET_LEVEL, 0: value of every synchroniser flop and `outbutton` bit in reset.
- REPEAT_DELAY, 0: ticks from press to first repeat pulse; 0 disables repeat.
- REPEAT_RATE, 1: ticks between subsequent repeat pulses (≥1).

- clk  input  1  single system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset; deassertion is synchronous to clk upstream.
- inbutton  input  CHANNELS  raw, asynchronous button levels.
- outbutton  output  CHANNELS  debounced level per channel.
- press  output  CHANNELS  one-cycle pulse on debounced 0→1.
- release  output  CHANNELS  one-cycle pulse on debounced 1→0.
- repeat  output  CHANNELS  one-cycle auto-repeat pulse while held.

## Operation
- Reset (reset=0, any time, asynchronous):
  - sync flops = RESET_LEVEL; outbutton = RESET_LEVEL.
  - Prescaler, stability counters and repeat counters are cleared.
  - press/release/repeat = 0.
- Synchroniser: 2 flops per channel. `s[i]` is the second-stage output.
- Prescaler: counts 0..SAMPLE_DIV-1 and wraps to 0. `tick` is high in the cycle the count equals SAMPLE_DIV-1. For SAMPLE_DIV=1, tick is constantly high. Width is $clog2(SAMPLE_DIV), minimum 1.
- Stability counter per channel, evaluated only on tick:
  - s[i]==outbutton[i]: cnt<=0.
  - s[i]!=outbutton[i] and cnt==STABLE_COUNT-1: outbutton[i]<=s[i]; cnt<=0.
  - otherwise: cnt<=cnt+1.
  - A single matching sample restarts the run; no partial credit.
- Event pulses are registered in the same cycle outbutton[i] updates:
  - press[i]=1 for exactly that cycle if the new level is 1.
  - release[i]=1 for exactly that cycle if the new level is 0.
  - Never both at once; never two consecutive cycles.
- Auto-repeat per channel (only when REPEAT_DELAY>0):
  - States IDLE, DELAY, RATE.
  - Press cycle: enter DELAY with rcnt=0.
  - DELAY: rcnt increments on each tick. On the tick where rcnt+1==REPEAT_DELAY, pulse repeat, rcnt<=0 and go to RATE.
  - RATE: same rule against REPEAT_RATE, staying in RATE.
  - Release cycle: back to IDLE with rcnt=0; no repeat pulse in the release cycle.
  - If REPEAT_DELAY=0, repeat stays 0 and the FSM stays in IDLE.
- Channels are fully independent. Simultaneous events on different channels all produce their pulses in the same cycle.

## Timing
- Latency with SAMPLE_DIV=1: take the first clk edge that samples the new inbutton value as edge 1. outbutton and press/release update at edge STABLE_COUNT+2.
- General latency: 2 cycles + wait to the next tick + (STABLE_COUNT-1)·SAMPLE_DIV cycles.
- Repeat with SAMPLE_DIV=1: press at edge P, repeat at P+REPEAT_DELAY, then every REPEAT_RATE edges while held.
- Glitches shorter than STABLE_COUNT ticks never reach outbutton.
- Reset mid-count discards all partial runs. After reset release, the first accepted change still needs the full STABLE_COUNT run.

## Test plan
Common configuration: CHANNELS=2, SAMPLE_DIV=1, STABLE_COUNT=4, REPEAT_DELAY=3, REPEAT_RATE=2 unless noted.

- Reset: hold reset=0 with inbutton=2'b11.
  - All outputs 0 during reset.
  - After release, outbutton=2'b11 and press[1:0] pulse together at edge 6.
- Clean press/release on ch0: inbutton[0] 0→1 sampled at edge 1.
  - outbutton[0]=1 and press[0]=1 only at edge 6.
  - Later 1→0 gives release[0] one cycle, 6 edges after its first sampling edge.
- Bounce on ch0: pattern 1,1,1,0,1,1,1,1.
  - No change during the first run.
  - outbutton[0] rises 6 edges after the final run of 1s begins; exactly one press pulse.
- Auto-repeat: hold ch1 high.
  - press[1] at edge P, then repeat[1] at P+3, P+5, P+7.
  - Release stops repeat; no repeat pulse coincides with release[1].
- Simultaneous channels: ch0 rises and ch1 falls on the same edge (ch1 previously 1).
  - press[0] and release[1] both high in the same cycle.
- Prescaled, plus reset mid-run: SAMPLE_DIV=3.
  - Changes are accepted only on tick cycles.
  - Asserting reset after 3 matching samples and then releasing it leaves outbutton=RESET_LEVEL, with no pulse until a new full 4-sample run completes.
